// File: rtl/minimax_mem_responder_if.sv
// Bus bundle between the minimax core, the memory responder and the
// single-port SRAM. The responder takes the slave view; the core/SRAM
// side (or a testbench) takes the master view.
interface minimax_mem_responder_if #(
    parameter int PC_BITS = 13
);
    // Core instruction port
    logic [PC_BITS-1:0] inst_addr;
    logic               inst_regce;
    logic [15:0]        inst;
    // Core data port
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [3:0]         wmask;
    logic               rreq;
    logic [31:0]        rdata;
    // SRAM port
    logic               sram_en;
    logic [PC_BITS-3:0] sram_addr;
    logic [3:0]         sram_wen;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;
    // Exit MMIO status
    logic               exit_valid;
    logic [31:0]        exit_code;

    modport slave (
        input  inst_addr, inst_regce, addr, wdata, wmask, rreq, sram_rdata,
        output inst, rdata, sram_en, sram_addr, sram_wen, sram_wdata,
               exit_valid, exit_code
    );

    modport master (
        output inst_addr, inst_regce, addr, wdata, wmask, rreq, sram_rdata,
        input  inst, rdata, sram_en, sram_addr, sram_wen, sram_wdata,
               exit_valid, exit_code
    );
endinterface

// File: rtl/minimax_mem_responder.sv
// Memory responder for the minimax core: arbitrates store > load > fetch
// onto one single-port SRAM, decodes the exit and cycle-counter MMIO words,
// and returns load data and instruction halfwords to the core.
module minimax_mem_responder #(
    parameter int          PC_BITS    = 13,
    parameter logic [31:0] EXIT_ADDR  = 32'hFFFFFFFC,
    parameter logic [31:0] CYCLE_ADDR = 32'hFFFFFFF8
) (
    input logic                     clk,
    input logic                     reset,
    minimax_mem_responder_if.slave  bus
);
    localparam int AW = PC_BITS - 2;

    logic          store_req;
    logic          load_req;
    logic          in_range;
    logic          fetch;

    logic          fetch_q,      fetch_d;
    logic          half_q,       half_d;
    logic          rd_sram_q,    rd_sram_d;
    logic [31:0]   rd_word_q,    rd_word_d;
    logic [15:0]   inst_q,       inst_d;
    logic [31:0]   cycle_q,      cycle_d;
    logic          exit_valid_q, exit_valid_d;
    logic [31:0]   exit_code_q,  exit_code_d;

    // Byte-lane bits below the word/halfword granularity are not needed.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{bus.inst_addr[0], bus.addr[1:0]};

    assign store_req = |bus.wmask;
    assign load_req  = bus.rreq && !store_req;
    assign in_range  = (bus.addr[31:PC_BITS] == '0);

    // Single-port arbitration: drive the SRAM from the winning request.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'h0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        fetch          = 1'b0;
        if (!reset) begin
            if (store_req) begin
                if (in_range) begin
                    bus.sram_en    = 1'b1;
                    bus.sram_wen   = bus.wmask;
                    bus.sram_addr  = bus.addr[PC_BITS-1:2];
                    bus.sram_wdata = bus.wdata;
                end
            end else if (load_req) begin
                if (in_range) begin
                    bus.sram_en   = 1'b1;
                    bus.sram_addr = bus.addr[PC_BITS-1:2];
                end
            end else begin
                bus.sram_en   = 1'b1;
                bus.sram_addr = bus.inst_addr[PC_BITS-1:2];
                fetch         = 1'b1;
            end
        end
    end

    // Next-state for read steering, instruction register, counter and exit.
    always_comb begin
        fetch_d      = fetch;
        half_d       = bus.inst_addr[1];
        rd_sram_d    = load_req && in_range;
        rd_word_d    = (load_req && bus.addr == CYCLE_ADDR) ? cycle_q : 32'h0;
        cycle_d      = cycle_q + 32'd1;
        inst_d       = inst_q;
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;
        if (bus.inst_regce) begin
            if (!fetch_q)    inst_d = 16'h0000;
            else if (half_q) inst_d = bus.sram_rdata[31:16];
            else             inst_d = bus.sram_rdata[15:0];
        end
        if (store_req && bus.wmask == 4'hF && bus.addr == EXIT_ADDR
            && !exit_valid_q) begin
            exit_valid_d = 1'b1;
            exit_code_d  = bus.wdata;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (reset) begin
            fetch_q      <= 1'b0;
            half_q       <= 1'b0;
            rd_sram_q    <= 1'b0;
            rd_word_q    <= 32'h0;
            inst_q       <= 16'h0000;
            cycle_q      <= 32'h0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= 32'h0;
        end else begin
            fetch_q      <= fetch_d;
            half_q       <= half_d;
            rd_sram_q    <= rd_sram_d;
            rd_word_q    <= rd_word_d;
            inst_q       <= inst_d;
            cycle_q      <= cycle_d;
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
        end
    end

    // Load data arrives with the SRAM's one-cycle latency; an in-flight
    // load is squashed as soon as reset is seen.
    assign bus.rdata      = reset ? 32'h0 : (rd_sram_q ? bus.sram_rdata : rd_word_q);
    assign bus.inst       = inst_q;
    assign bus.exit_valid = exit_valid_q;
    assign bus.exit_code  = exit_code_q;
endmodule

// File: tb/tb_minimax_mem_responder.sv
// Directed self-checking bench for minimax_mem_responder with a behavioural
// single-port SRAM attached.
module tb_minimax_mem_responder;
    localparam int PC_BITS = 13;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    minimax_mem_responder_if #(.PC_BITS(PC_BITS)) bus ();

    minimax_mem_responder #(.PC_BITS(PC_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: byte writes, one-cycle read latency.
    logic [31:0] mem [0:(1 << (PC_BITS - 2)) - 1];
    logic [31:0] sram_q = 32'h0;
    assign bus.sram_rdata = sram_q;

    initial for (int i = 0; i < (1 << (PC_BITS - 2)); i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_wen != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_wen[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            end else begin
                sram_q <= mem[bus.sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wmask      = 4'h0;
        bus.rreq       = 1'b0;
        bus.inst_regce = 1'b0;
        bus.addr       = 32'h0;
        bus.wdata      = 32'h0;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic r);
        bus.addr  = a;
        bus.wdata = d;
        bus.wmask = m;
        bus.rreq  = r;
    endtask

    initial begin
        bus.inst_addr = '0;
        idle();

        // Reset with every request active: SRAM port must stay quiet.
        drive(32'h10, 32'h1, 4'hF, 1'b1);
        bus.inst_addr  = 13'h6;
        bus.inst_regce = 1'b1;
        step();
        step();
        check("rst_sram_en",  {31'h0, bus.sram_en}, 32'h0);
        check("rst_sram_wen", {28'h0, bus.sram_wen}, 32'h0);
        check("rst_sram_addr", {21'h0, bus.sram_addr}, 32'h0);
        check("rst_inst",     {16'h0, bus.inst}, 32'h0);
        check("rst_rdata",    bus.rdata, 32'h0);
        check("rst_exit_valid", {31'h0, bus.exit_valid}, 32'h0);
        check("rst_exit_code", bus.exit_code, 32'h0);

        // Counter read 100 cycles after reset release.
        idle();
        reset = 1'b0;
        repeat (100) step();
        drive(32'hFFFFFFF8, 32'h0, 4'h0, 1'b1);
        #1 check("cyc_load_no_en", {31'h0, bus.sram_en}, 32'h0);
        step();
        check("cyc_100", bus.rdata, 32'd100);
        drive(32'h80000000, 32'h0, 4'h0, 1'b1);
        step();
        check("oor_load", bus.rdata, 32'h0);

        // Store then load back.
        drive(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        #1;
        check("st_en",    {31'h0, bus.sram_en}, 32'h1);
        check("st_wen",   {28'h0, bus.sram_wen}, 32'hF);
        check("st_addr",  {21'h0, bus.sram_addr}, 32'h4);
        check("st_wdata", bus.sram_wdata, 32'hDEADBEEF);
        step();
        check("st_rdata0", bus.rdata, 32'h0);
        drive(32'h10, 32'h0, 4'h0, 1'b1);
        #1 check("ld_wen", {28'h0, bus.sram_wen}, 32'h0);
        step();
        check("ld_data", bus.rdata, 32'hDEADBEEF);
        idle();
        step();
        check("no_load_rdata0", bus.rdata, 32'h0);

        // Instruction fetch from both halves of word 1.
        drive(32'h4, 32'h1234ABCD, 4'hF, 1'b0);
        step();
        idle();
        bus.inst_addr = 13'h6;
        #1;
        check("fetch_en",   {31'h0, bus.sram_en}, 32'h1);
        check("fetch_addr", {21'h0, bus.sram_addr}, 32'h1);
        step();
        bus.inst_regce = 1'b1;
        step();
        check("inst_hi", {16'h0, bus.inst}, 32'h1234);
        bus.inst_regce = 1'b0;
        bus.inst_addr  = 13'h4;
        step();
        bus.inst_regce = 1'b1;
        step();
        check("inst_lo", {16'h0, bus.inst}, 32'hABCD);
        bus.inst_regce = 1'b0;
        bus.inst_addr  = 13'h6;
        step();
        step();
        check("inst_hold", {16'h0, bus.inst}, 32'hABCD);
        drive(32'h40, 32'h0, 4'hF, 1'b0);
        step();
        idle();
        bus.inst_regce = 1'b1;
        step();
        check("inst_after_store", {16'h0, bus.inst}, 32'h0);

        // Simultaneous store and load: store wins, load data is zero.
        idle();
        drive(32'h10, 32'h0, 4'h0, 1'b1);
        step();
        drive(32'h24, 32'hCAFEF00D, 4'hF, 1'b1);
        check("pre_both_rdata", bus.rdata, 32'hDEADBEEF);
        #1;
        check("both_addr", {21'h0, bus.sram_addr}, 32'h9);
        check("both_wen",  {28'h0, bus.sram_wen}, 32'hF);
        step();
        check("both_rdata0", bus.rdata, 32'h0);
        drive(32'h24, 32'h0, 4'h0, 1'b1);
        step();
        check("both_stored", bus.rdata, 32'hCAFEF00D);

        // Exit MMIO: partial mask ignored, first full write sticks.
        drive(32'hFFFFFFFC, 32'h7, 4'h3, 1'b0);
        #1 check("exit_part_en", {31'h0, bus.sram_en}, 32'h0);
        step();
        check("exit_part_valid", {31'h0, bus.exit_valid}, 32'h0);
        drive(32'hFFFFFFFC, 32'h0, 4'hF, 1'b0);
        #1 check("exit0_en", {31'h0, bus.sram_en}, 32'h0);
        step();
        check("exit0_valid", {31'h0, bus.exit_valid}, 32'h1);
        check("exit0_code",  bus.exit_code, 32'h0);
        drive(32'hFFFFFFFC, 32'h5, 4'hF, 1'b0);
        #1 check("exit5_en", {31'h0, bus.sram_en}, 32'h0);
        step();
        check("exit5_valid", {31'h0, bus.exit_valid}, 32'h1);
        check("exit5_code",  bus.exit_code, 32'h0);

        // Counter wrap from an injected all-ones value.
        idle();
        dut.cycle_q = 32'hFFFFFFFF;
        drive(32'hFFFFFFF8, 32'h0, 4'h0, 1'b1);
        step();
        check("cyc_ffff", bus.rdata, 32'hFFFFFFFF);
        step();
        check("cyc_wrap", bus.rdata, 32'h0);

        // Reset arriving with a load and a fetch outstanding.
        idle();
        bus.inst_addr = 13'h4;
        step();
        bus.inst_regce = 1'b1;
        step();
        check("pre_rst_inst", {16'h0, bus.inst}, 32'hABCD);
        idle();
        drive(32'h10, 32'h0, 4'h0, 1'b1);
        step();
        reset = 1'b1;
        drive(32'h10, 32'h1, 4'hF, 1'b1);
        #1;
        check("rst2_rdata", bus.rdata, 32'h0);
        check("rst2_en",    {31'h0, bus.sram_en}, 32'h0);
        step();
        check("rst2_inst",  {16'h0, bus.inst}, 32'h0);
        check("rst2_en2",   {31'h0, bus.sram_en}, 32'h0);
        idle();
        bus.inst_regce = 1'b1;
        reset = 1'b0;
        check("post_rst_rdata", bus.rdata, 32'h0);
        step();
        check("post_rst_inst", {16'h0, bus.inst}, 32'h0);
        check("post_rst_cnt_exit", {31'h0, bus.exit_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
